rpn_calc: RTL and testbench
===========================

// Module: rpn_calc
// PURPOSE
//  RPN (postfix) calculator that is the initiator of the stack command interface (nop/push/pop).
//  Takes one token per handshake and drives an external LIFO stack of 2**ADDR_BITS words.
//  A token is a literal push or an operator; operators pop operands, compute and push the result.
//  Sits between a token source (UART decoder / test sequencer) and the stack instance.
// PARAMETERS
//  ADDR_BITS  3  stack address width; capacity NUM_WORDS = 2**ADDR_BITS
//  WORD_BITS  8  data/operand width
// PORTS
//  in_clk          in   1            clock; all logic on posedge
//  in_rst          in   1            synchronous reset, active-low (0 = reset); same net resets the stack
//  in_valid        in   1            token valid
//  in_op           in   3            token opcode (see BEHAVIOUR)
//  in_data         in   WORD_BITS    literal for PUSH
//  out_ready       out  1            token accepted when in_valid & out_ready
//  out_done        out  1            one-cycle pulse: token finished
//  out_err         out  1            valid with out_done: token rejected, stack unchanged
//  out_result      out  WORD_BITS    top of stack after last token (0 when empty)
//  out_depth       out  ADDR_BITS+1  number of stacked words, 0..NUM_WORDS
//  out_stack_cmd   out  2            to stack: 00 nop, 01 push, 10 pop
//  out_stack_data  out  WORD_BITS    to stack: word to push
//  in_stack_top    in   WORD_BITS    from stack: current top word
//  in_stack_ready  in   1            from stack: ready for command
// BEHAVIOUR
//  - Reset: state Idle, out_ready=1, out_done=0, out_err=0, out_result=0, out_depth=0, out_stack_cmd=00, out_stack_data=0.
//  - Opcodes: 000 PUSH, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 DROP, 110 DUP, 111 MUL (macro only).
//  - out_ready=1 only in Idle; the token is latched on acceptance; inputs are ignored while busy.
//  - Stack protocol: a non-nop cmd is driven for exactly one cycle, and only in a cycle where in_stack_ready=1.
//    The controller then drives 00 for at least one cycle (guard: ready ignored in that cycle).
//    It waits for in_stack_ready=1 before sampling in_stack_top or issuing the next command.
//  - States: Idle -> Check -> {PopA, WaitA, PopB, WaitB, Calc, Push, WaitPush} -> Done -> Idle.
//  - Check: underflow when DROP/DUP at depth 0 or binary op at depth<2.
//    Overflow when PUSH/DUP at depth NUM_WORDS.
//    Error -> Done with out_err=1; no stack command is issued.
//  - Binary op: A = top (sampled, then popped), B = next (sampled, then popped).
//    result = B op A, pushed back; net depth -1.
//  - SUB = B - A, ADD/MUL truncated to WORD_BITS; wrap modulo 2**WORD_BITS, no carry or overflow flag.
//  - DUP: sample top, push it (depth +1). DROP: pop (depth -1). PUSH: push in_data (depth +1).
//  - out_depth is updated when each push/pop command is issued.
//  - out_result: registered in Done from in_stack_top (in_stack_ready=1 there); forced to 0 when depth=0.
//  - Latency: PUSH on an always-ready stack: accept c0, cmd=01 c1, guard c2, ready seen c3, out_done=1 c4, out_ready=1 c5.
//  - Stack stalls (ready=0) extend the wait states indefinitely; no timeout.
//  - Reset mid-token: token dropped, everything returns to reset values; the stack is reset by the same net, so depth 0 stays consistent.
// CONFIGURATION
//  RPN_MUL_EN defined: opcode 111 = MUL, result = low WORD_BITS of B*A.
//  RPN_MUL_EN undefined: opcode 111 is illegal -> out_done with out_err=1, no stack command, depth unchanged.
// STRUCTURE
//  Package rpn_pkg:
//    t_op enum (the 8 opcodes)
//    t_stack_cmd (CMD_NOP=2'b00, CMD_PUSH=2'b01, CMD_POP=2'b10)
//    t_rpn_state enum
//  Sub-module rpn_alu: combinational (op, a, b) -> result, WORD_BITS wide; holds the RPN_MUL_EN branch.
//  rpn_calc: FSM, depth counter, handshake, output registers.
// TESTING (bench instantiates rpn_calc + stack, ADDR_BITS=3, WORD_BITS=8)
//  PUSH 5, PUSH 3, SUB -> out_result=2, depth=1, out_err=0; PUSH timing exactly c0..c5 as above.
//  PUSH 200, PUSH 100, ADD -> out_result=44 (wrap); then DUP, AND -> 44, depth=1.
//  Empty: ADD -> out_err=1, depth=0, out_stack_cmd never non-zero; DROP -> out_err=1.
//  9 x PUSH i (i=1..9) -> 9th gets out_err=1, depth=8, out_result=8.
//  Opcode 111 with 7 and 6 stacked -> 42 with RPN_MUL_EN, out_err=1 and depth=2 without.
//  Assert in_rst=0 during WaitA of an ADD -> next cycle out_ready=1, depth=0, out_result=0, out_stack_cmd=00.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator: opcodes, stack command encoding and controller states.
// Opcode 111 (MUL) is only legal when RPN_MUL_EN is defined; see rpn_alu.
package rpn_pkg;

    typedef enum logic [2:0] {
        OP_PUSH = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_DROP = 3'b101,
        OP_DUP  = 3'b110,
        OP_MUL  = 3'b111
    } t_op;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10
    } t_stack_cmd;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CHECK     = 4'd1,
        ST_POP_A     = 4'd2,
        ST_WAIT_A    = 4'd3,
        ST_POP_B     = 4'd4,
        ST_WAIT_B    = 4'd5,
        ST_CALC      = 4'd6,
        ST_PUSH      = 4'd7,
        ST_WAIT_PUSH = 4'd8,
        ST_DONE      = 4'd9
    } t_rpn_state;

    function automatic logic op_is_binary(input t_op op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational operator unit: result = b op a, truncated to WORD_BITS.
// RPN_MUL_EN enables opcode 111 as MUL; otherwise it is flagged illegal.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WORD_BITS = 8
)(
    input  t_op                  op,
    input  logic [WORD_BITS-1:0] a,
    input  logic [WORD_BITS-1:0] b,
    output logic [WORD_BITS-1:0] result,
    output logic                 illegal
);

    // Operator decode; non-arithmetic opcodes produce zero and are never consumed
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  result = b + a;
            OP_SUB:  result = b - a;
            OP_AND:  result = b & a;
            OP_OR:   result = b | a;
`ifdef RPN_MUL_EN
            OP_MUL:  result = b * a;
`else
            OP_MUL:  illegal = 1'b1;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rpn_calc.sv
// RPN calculator controller driving an external LIFO over a nop/push/pop command port.
// Build option: RPN_MUL_EN (handled inside rpn_alu) turns opcode 111 into MUL.
module rpn_calc
    import rpn_pkg::*;
#(
    parameter int ADDR_BITS = 3,
    parameter int WORD_BITS = 8
)(
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_valid,
    input  logic [2:0]           in_op,
    input  logic [WORD_BITS-1:0] in_data,
    output logic                 out_ready,
    output logic                 out_done,
    output logic                 out_err,
    output logic [WORD_BITS-1:0] out_result,
    output logic [ADDR_BITS:0]   out_depth,
    output logic [1:0]           out_stack_cmd,
    output logic [WORD_BITS-1:0] out_stack_data,
    input  logic [WORD_BITS-1:0] in_stack_top,
    input  logic                 in_stack_ready
);

    localparam int DEPTH_W = ADDR_BITS + 1;
    localparam logic [ADDR_BITS:0] DEPTH_ZERO = DEPTH_W'(0);
    localparam logic [ADDR_BITS:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [ADDR_BITS:0] DEPTH_TWO  = DEPTH_W'(2);
    localparam logic [ADDR_BITS:0] DEPTH_FULL = DEPTH_W'(2 ** ADDR_BITS);

    t_rpn_state           state_r;
    t_op                  op_r;
    logic [WORD_BITS-1:0] data_r;
    logic [WORD_BITS-1:0] a_r;
    logic [WORD_BITS-1:0] b_r;
    logic                 err_r;

    logic [WORD_BITS-1:0] alu_result_s;
    logic                 op_illegal_s;
    logic                 check_err_s;

    rpn_alu #(
        .WORD_BITS (WORD_BITS)
    ) u_alu (
        .op      (op_r),
        .a       (a_r),
        .b       (b_r),
        .result  (alu_result_s),
        .illegal (op_illegal_s)
    );

    // Under/overflow and illegal-opcode screening of the latched token
    always_comb begin
        check_err_s = 1'b0;
        if (op_illegal_s) begin
            check_err_s = 1'b1;
        end else begin
            case (op_r)
                OP_PUSH: check_err_s = (out_depth == DEPTH_FULL);
                OP_DUP:  check_err_s = (out_depth == DEPTH_FULL) || (out_depth == DEPTH_ZERO);
                OP_DROP: check_err_s = (out_depth == DEPTH_ZERO);
                default: check_err_s = (out_depth < DEPTH_TWO);
            endcase
        end
    end

    // Token sequencer; every issued command lasts one cycle and is followed by a nop guard cycle
    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state_r        <= ST_IDLE;
            op_r           <= OP_PUSH;
            data_r         <= '0;
            a_r            <= '0;
            b_r            <= '0;
            err_r          <= 1'b0;
            out_ready      <= 1'b1;
            out_done       <= 1'b0;
            out_err        <= 1'b0;
            out_result     <= '0;
            out_depth      <= DEPTH_ZERO;
            out_stack_cmd  <= CMD_NOP;
            out_stack_data <= '0;
        end else begin
            out_stack_cmd <= CMD_NOP;
            out_done      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    out_ready <= 1'b1;
                    if (in_valid && out_ready) begin
                        op_r      <= t_op'(in_op);
                        data_r    <= in_data;
                        out_ready <= 1'b0;
                        state_r   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_r <= check_err_s;
                    if (check_err_s) begin
                        state_r <= ST_DONE;
                    end else if (in_stack_ready) begin
                        case (op_r)
                            OP_PUSH: begin
                                out_stack_cmd  <= CMD_PUSH;
                                out_stack_data <= data_r;
                                out_depth      <= out_depth + DEPTH_ONE;
                                state_r        <= ST_PUSH;
                            end
                            OP_DUP: begin
                                out_stack_cmd  <= CMD_PUSH;
                                out_stack_data <= in_stack_top;
                                out_depth      <= out_depth + DEPTH_ONE;
                                state_r        <= ST_PUSH;
                            end
                            default: begin
                                a_r           <= in_stack_top;
                                out_stack_cmd <= CMD_POP;
                                out_depth     <= out_depth - DEPTH_ONE;
                                state_r       <= ST_POP_A;
                            end
                        endcase
                    end
                end
                ST_POP_A: state_r <= ST_WAIT_A;
                ST_WAIT_A: begin
                    if (in_stack_ready) begin
                        if (op_is_binary(op_r)) begin
                            b_r           <= in_stack_top;
                            out_stack_cmd <= CMD_POP;
                            out_depth     <= out_depth - DEPTH_ONE;
                            state_r       <= ST_POP_B;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_POP_B: state_r <= ST_WAIT_B;
                ST_WAIT_B: begin
                    if (in_stack_ready) begin
                        state_r <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (in_stack_ready) begin
                        out_stack_cmd  <= CMD_PUSH;
                        out_stack_data <= alu_result_s;
                        out_depth      <= out_depth + DEPTH_ONE;
                        state_r        <= ST_PUSH;
                    end
                end
                ST_PUSH: state_r <= ST_WAIT_PUSH;
                ST_WAIT_PUSH: begin
                    if (in_stack_ready) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (in_stack_ready) begin
                        out_done   <= 1'b1;
                        out_err    <= err_r;
                        out_result <= (out_depth == DEPTH_ZERO) ? '0 : in_stack_top;
                        state_r    <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_calc.sv
// Bench for rpn_calc with a behavioural LIFO (random stalls) and a queue-based RPN reference model.
module tb_rpn_calc;

    localparam int NW = 8;
`ifdef RPN_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_op = 3'd0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready, out_done, out_err;
    logic [7:0] out_result, out_stack_data, stk_top;
    logic [3:0] out_depth;
    logic [1:0] out_stack_cmd;
    logic       stk_ready;

    int checks = 0;
    int errors = 0;
    int stall_max = 0;
    int cmd_count = 0;
    int mdl[$];

    rpn_calc #(.ADDR_BITS(3), .WORD_BITS(8)) dut (
        .in_clk         (clk),
        .in_rst         (rst_n),
        .in_valid       (in_valid),
        .in_op          (in_op),
        .in_data        (in_data),
        .out_ready      (out_ready),
        .out_done       (out_done),
        .out_err        (out_err),
        .out_result     (out_result),
        .out_depth      (out_depth),
        .out_stack_cmd  (out_stack_cmd),
        .out_stack_data (out_stack_data),
        .in_stack_top   (stk_top),
        .in_stack_ready (stk_ready)
    );

    always #5 clk = ~clk;

    // Behavioural stack: accepts a command per cycle, then stalls for a random number of cycles
    logic [7:0] stk_mem [0:NW-1];
    int         stk_sp, stk_cnt, stall_pick;
    logic [1:0] prev_cmd;
    logic       bad;
    assign stk_top = (stk_sp == 0) ? 8'd0 : stk_mem[stk_sp-1];

    always @(posedge clk) begin
        if (!rst_n) begin
            stk_sp <= 0; stk_cnt <= 0; stk_ready <= 1'b1; prev_cmd <= 2'b00;
        end else begin
            prev_cmd <= out_stack_cmd;
            if (out_stack_cmd != 2'b00) begin
                cmd_count++;
                checks++;
                bad = !stk_ready || (prev_cmd != 2'b00) || (out_stack_cmd == 2'b11) ||
                      (out_stack_cmd == 2'b01 && stk_sp >= NW) || (out_stack_cmd == 2'b10 && stk_sp == 0);
                if (bad) begin
                    errors++;
                    $display("FAIL stack_protocol: cmd=%0d ready=%0d prev_cmd=%0d sp=%0d, want ready=1 prev_cmd=0 in-range sp",
                             out_stack_cmd, stk_ready, prev_cmd, stk_sp);
                end
                if (out_stack_cmd == 2'b01 && stk_sp < NW) begin
                    stk_mem[stk_sp] <= out_stack_data;
                    stk_sp <= stk_sp + 1;
                end else if (out_stack_cmd == 2'b10 && stk_sp > 0) begin
                    stk_sp <= stk_sp - 1;
                end
                stall_pick = $urandom_range(0, stall_max);
                stk_cnt   <= stall_pick;
                stk_ready <= (stall_pick == 0);
            end else if (stk_cnt != 0) begin
                stk_cnt   <= stk_cnt - 1;
                stk_ready <= (stk_cnt == 1);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference RPN semantics on a plain queue; returns expected error flag and command count
    task automatic model_apply(input logic [2:0] op, input logic [7:0] d, output logic e, output int ncmd);
        int n, a, b, r;
        n = mdl.size(); e = 1'b0; ncmd = 0; r = 0;
        case (op)
            3'd0: if (n >= NW) e = 1'b1; else begin mdl.push_back(int'(d)); ncmd = 1; end
            3'd5: if (n == 0) e = 1'b1; else begin void'(mdl.pop_back()); ncmd = 1; end
            3'd6: if (n == 0 || n >= NW) e = 1'b1; else begin mdl.push_back(mdl[n-1]); ncmd = 1; end
            default: begin
                if (n < 2 || (op == 3'd7 && !MUL_EN)) begin
                    e = 1'b1;
                end else begin
                    a = mdl.pop_back();
                    b = mdl.pop_back();
                    case (op)
                        3'd1: r = b + a;
                        3'd2: r = b - a;
                        3'd3: r = b & a;
                        3'd4: r = b | a;
                        default: r = b * a;
                    endcase
                    mdl.push_back(r & 255);
                    ncmd = 3;
                end
            end
        endcase
    endtask

    task automatic run_token(input logic [2:0] op, input logic [7:0] data, input string tag);
        int n, c0, ncmd, want_res;
        logic want_err;
        n = 0;
        while (out_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check({tag, " ready_seen"}, 32'(out_ready), 32'd1);
        c0 = cmd_count;
        model_apply(op, data, want_err, ncmd);
        in_valid = 1'b1; in_op = op; in_data = data;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check({tag, " done_seen"}, 32'(out_done), 32'd1);
        want_res = (mdl.size() == 0) ? 0 : mdl[$];
        check({tag, " err"}, 32'(out_err), 32'(want_err));
        check({tag, " depth"}, 32'(out_depth), 32'(mdl.size()));
        check({tag, " result"}, 32'(out_result), 32'(want_res));
        check({tag, " cmd_count"}, 32'(cmd_count - c0), 32'(ncmd));
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl.delete();
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic       err;
        logic [7:0] res;
        logic [3:0] depth;
    } vec_t;

    vec_t tbl[$];
    logic [3:0] lat_want [0:5];
    logic [3:0] lat_got;

    initial begin
        tbl.push_back('{3'd0, 8'd5,   1'b0, 8'd5,   4'd1});
        tbl.push_back('{3'd0, 8'd3,   1'b0, 8'd3,   4'd2});
        tbl.push_back('{3'd2, 8'd0,   1'b0, 8'd2,   4'd1});
        tbl.push_back('{3'd5, 8'd0,   1'b0, 8'd0,   4'd0});
        tbl.push_back('{3'd0, 8'd200, 1'b0, 8'd200, 4'd1});
        tbl.push_back('{3'd0, 8'd100, 1'b0, 8'd100, 4'd2});
        tbl.push_back('{3'd1, 8'd0,   1'b0, 8'd44,  4'd1});
        tbl.push_back('{3'd6, 8'd0,   1'b0, 8'd44,  4'd2});
        tbl.push_back('{3'd3, 8'd0,   1'b0, 8'd44,  4'd1});
        tbl.push_back('{3'd5, 8'd0,   1'b0, 8'd0,   4'd0});
        tbl.push_back('{3'd1, 8'd0,   1'b1, 8'd0,   4'd0});
        tbl.push_back('{3'd5, 8'd0,   1'b1, 8'd0,   4'd0});
        tbl.push_back('{3'd6, 8'd0,   1'b1, 8'd0,   4'd0});
        tbl.push_back('{3'd0, 8'd12,  1'b0, 8'd12,  4'd1});
        tbl.push_back('{3'd0, 8'd3,   1'b0, 8'd3,   4'd2});
        tbl.push_back('{3'd4, 8'd0,   1'b0, 8'd15,  4'd1});
        tbl.push_back('{3'd2, 8'd0,   1'b1, 8'd15,  4'd1});
        tbl.push_back('{3'd5, 8'd0,   1'b0, 8'd0,   4'd0});
        tbl.push_back('{3'd0, 8'd7,   1'b0, 8'd7,   4'd1});
        tbl.push_back('{3'd0, 8'd6,   1'b0, 8'd6,   4'd2});
        tbl.push_back('{3'd7, 8'd0, !MUL_EN, MUL_EN ? 8'd42 : 8'd6, MUL_EN ? 4'd1 : 4'd2});

        // Reset values
        repeat (3) @(negedge clk);
        check("rst out_ready", 32'(out_ready), 32'd1);
        check("rst out_done", 32'(out_done), 32'd0);
        check("rst out_err", 32'(out_err), 32'd0);
        check("rst out_result", 32'(out_result), 32'd0);
        check("rst out_depth", 32'(out_depth), 32'd0);
        check("rst out_stack_cmd", 32'(out_stack_cmd), 32'd0);
        check("rst out_stack_data", 32'(out_stack_data), 32'd0);
        rst_n = 1'b1;

        // PUSH latency on an always-ready stack: {ready, done, cmd} after each edge
        lat_want[0] = 4'b0000; lat_want[1] = 4'b0001; lat_want[2] = 4'b0000;
        lat_want[3] = 4'b0000; lat_want[4] = 4'b0100; lat_want[5] = 4'b1000;
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_data = 8'd42;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat_got = {out_ready, out_done, out_stack_cmd};
            check($sformatf("latency c%0d", k), 32'(lat_got), 32'(lat_want[k]));
            if (k == 1) check("latency push data", 32'(out_stack_data), 32'd42);
            if (k == 4) check("latency result", 32'(out_result), 32'd42);
        end
        mdl.push_back(42);

        // Directed table with light stack stalls
        do_reset();
        stall_max = 1;
        for (int i = 0; i < tbl.size(); i++) begin
            run_token(tbl[i].op, tbl[i].data, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d vec_err", i), 32'(out_err), 32'(tbl[i].err));
            check($sformatf("tbl%0d vec_result", i), 32'(out_result), 32'(tbl[i].res));
            check($sformatf("tbl%0d vec_depth", i), 32'(out_depth), 32'(tbl[i].depth));
        end

        // Overflow: ninth push is rejected
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            run_token(3'd0, 8'(i), $sformatf("fill%0d", i));
            check($sformatf("fill%0d vec_err", i), 32'(out_err), (i == 9) ? 32'd1 : 32'd0);
            check($sformatf("fill%0d vec_depth", i), 32'(out_depth), (i == 9) ? 32'd8 : 32'(i));
            check($sformatf("fill%0d vec_result", i), 32'(out_result), (i == 9) ? 32'd8 : 32'(i));
        end

        // Reset asserted while an ADD waits after its first pop
        do_reset();
        stall_max = 0;
        run_token(3'd0, 8'd1, "mid push1");
        run_token(3'd0, 8'd2, "mid push2");
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst out_ready", 32'(out_ready), 32'd1);
        check("midrst out_depth", 32'(out_depth), 32'd0);
        check("midrst out_result", 32'(out_result), 32'd0);
        check("midrst out_stack_cmd", 32'(out_stack_cmd), 32'd0);
        rst_n = 1'b1;
        mdl.delete();
        run_token(3'd0, 8'd9, "after midrst");

        // Random tokens against the reference model with random stalls
        do_reset();
        stall_max = 3;
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 10);
            run_token((r <= 3) ? 3'd0 : 3'(r - 3), 8'($urandom_range(0, 255)), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
